// File: rtl/wei_feed_pkg.sv
// Shared types and defaults for the weight-feed sequencing controller.
package wei_feed_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StCswWait,
        StDrain,
        StDone
    } feed_state_e;

    localparam int unsigned PIPE_LAT_DEF = 2;

endpackage

// File: rtl/wei_feed_drain_cnt.sv
// Drain down-counter: loads PIPE_LAT, decrements on enabled cycles and flags the final count.
module wei_feed_drain_cnt
    import wei_feed_pkg::*;
#(
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_load,
    input  logic i_en,
    output logic o_last
);

    localparam int unsigned CNT_W = $clog2(PIPE_LAT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PIPE_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= LOAD_VAL;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // High while the next enabled cycle is the last one the pipeline needs.
    assign o_last = (cnt_q == CNT_ONE);

endmodule

// File: rtl/wei_feed_ctrl.sv
// Weight-feed sequencing controller: clears, runs, context-switches and drains one weight tile.
// Defining WEI_FEED_CTRL_PERF_EN adds the o_stall_cycles stall counter.
module wei_feed_ctrl
    import wei_feed_pkg::*;
#(
    parameter int unsigned CTX_W    = 8,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
`ifdef WEI_FEED_CTRL_PERF_EN
    ,
    parameter int unsigned PERF_W   = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CTX_W-1:0] i_ctx_total,
    input  logic [CTX_W-1:0] i_reps,
    input  logic             i_feed_rdy,
    input  logic             i_cswitch_ok,
    input  logic             i_idx_done,
    input  logic             i_idx_til_done,
    output logic             o_cnt_en,
    output logic             o_cnt_clear,
    output logic             o_cswitch,
    output logic             o_sram_rden,
    output logic             o_busy,
    output logic [CTX_W-1:0] o_ctx_idx,
    output logic             o_tile_done,
    output logic             o_err
`ifdef WEI_FEED_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] o_stall_cycles
`endif
);

    localparam logic [CTX_W-1:0] CTX_ONE = CTX_W'(1);

    feed_state_e      state_q;
    logic [CTX_W-1:0] ctx_total_q;
    logic [CTX_W-1:0] reps_q;
    logic [CTX_W-1:0] ctx_idx_q;
    logic [CTX_W-1:0] rep_cnt_q;
    logic             err_q;
    logic             clr_q;

    logic ctx_last;
    logic cswitch;
    logic drain_load;
    logic drain_en;
    logic drain_last;

    assign ctx_last   = (ctx_idx_q == (ctx_total_q - CTX_ONE));
    assign cswitch    = (state_q == StRun) && (rep_cnt_q == (reps_q - CTX_ONE));
    assign drain_load = (state_q == StRun) && i_idx_til_done && !i_stop;
    assign drain_en   = (state_q == StDrain) && i_feed_rdy;

    wei_feed_drain_cnt #(
        .PIPE_LAT (PIPE_LAT)
    ) u_drain_cnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_load (drain_load),
        .i_en   (drain_en),
        .o_last (drain_last)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= StIdle;
            ctx_total_q <= '0;
            reps_q      <= '0;
            ctx_idx_q   <= '0;
            rep_cnt_q   <= '0;
            err_q       <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            if (i_stop && (state_q != StIdle)) begin
                // Abort: leave counters and error untouched, just clear the datapath.
                state_q <= StIdle;
                clr_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (i_start) begin
                            state_q     <= StClear;
                            ctx_total_q <= (i_ctx_total == '0) ? CTX_ONE : i_ctx_total;
                            reps_q      <= (i_reps == '0) ? CTX_ONE : i_reps;
                            ctx_idx_q   <= '0;
                            rep_cnt_q   <= '0;
                            err_q       <= 1'b0;
                            clr_q       <= 1'b1;
                        end
                    end
                    StClear: state_q <= StRun;
                    StRun: begin
                        if (i_idx_til_done) begin
                            if (!ctx_last) begin
                                err_q <= 1'b1;
                            end
                            state_q <= StDrain;
                        end else if (i_idx_done) begin
                            if (cswitch) begin
                                rep_cnt_q <= '0;
                                ctx_idx_q <= ctx_last ? '0 : ctx_idx_q + CTX_ONE;
                                if (!i_cswitch_ok) begin
                                    state_q <= StCswWait;
                                end
                            end else begin
                                rep_cnt_q <= rep_cnt_q + CTX_ONE;
                            end
                        end
                    end
                    StCswWait: begin
                        if (i_cswitch_ok) begin
                            state_q <= StRun;
                        end
                    end
                    StDrain: begin
                        if (drain_en && drain_last) begin
                            state_q <= StDone;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        o_cnt_en    = 1'b0;
        o_sram_rden = 1'b0;
        unique case (state_q)
            StRun: begin
                o_cnt_en    = i_feed_rdy;
                o_sram_rden = i_feed_rdy;
            end
            StDrain: o_cnt_en = i_feed_rdy;
            default: begin
                o_cnt_en    = 1'b0;
                o_sram_rden = 1'b0;
            end
        endcase
    end

    assign o_cnt_clear = clr_q;
    assign o_cswitch   = cswitch;
    assign o_busy      = (state_q != StIdle);
    assign o_ctx_idx   = ctx_idx_q;
    assign o_tile_done = (state_q == StDone);
    assign o_err       = err_q;

`ifdef WEI_FEED_CTRL_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [PERF_W-1:0] stall_q;
    logic              stall_inc;

    assign stall_inc = (state_q == StCswWait) ||
                       (!i_feed_rdy && ((state_q == StRun) || (state_q == StDrain)));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_q <= '0;
        end else if ((state_q == StIdle) && i_start) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != {PERF_W{1'b1}})) begin
            stall_q <= stall_q + PERF_ONE;
        end
    end

    assign o_stall_cycles = stall_q;
`endif

endmodule
